// File: rtl/par_ser_shift_reg_if.sv
// par_ser_shift_reg_if: load handshake, pacing/abort controls and serial pad outputs of the parallel-to-serial transmitter.
interface par_ser_shift_reg_if #(
    parameter int NumBits = 48
);
    logic [NumBits-1:0] dat_par_i;
    logic               load_valid_i;
    logic               load_ready_o;
    logic               shift_out_en_i;
    logic               abort_i;
    logic               dat_ser_o;
    logic               dat_ser_oe_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output dat_par_i, load_valid_i, shift_out_en_i, abort_i,
        input  load_ready_o, dat_ser_o, dat_ser_oe_o, busy_o, done_o
    );

    modport slave (
        input  dat_par_i, load_valid_i, shift_out_en_i, abort_i,
        output load_ready_o, dat_ser_o, dat_ser_oe_o, busy_o, done_o
    );
endinterface

// File: rtl/par_ser_shift_reg.sv
// par_ser_shift_reg: MSb-first parallel-to-serial transmitter for SD CMD/DAT lines, paced by a bit-slot strobe.
// Optional PAR_SER_CRC7_EN appends a CRC7 (x^7+x^3+1) after the data bits.
module par_ser_shift_reg #(
    parameter int   NumBits   = 48,
    parameter logic IdleLevel = 1'b1
) (
    input logic                 clk_i,
    input logic                 rst_i,
    par_ser_shift_reg_if.slave  bus
);
    localparam int CW = $clog2(NumBits + 8);
`ifdef PAR_SER_CRC7_EN
    localparam int Slots = NumBits + 7;
`else
    localparam int Slots = NumBits;
`endif
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]         state;
    logic [NumBits-1:0] sr;
    logic [CW-1:0]      cnt;
    logic               done;
    logic               ser_bit;

`ifdef PAR_SER_CRC7_EN
    logic [6:0] crc;
    logic       data_phase;
    // The last 7 slots of a frame carry the CRC instead of shift register data.
    assign data_phase = cnt > CW'(7);
    assign ser_bit    = data_phase ? sr[NumBits-1] : crc[6];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            crc <= '0;
        else if (bus.abort_i || (state == IDLE && bus.load_valid_i))
            crc <= '0;
        else if (state == SHIFT && bus.shift_out_en_i)
            crc <= data_phase ? ({crc[5:0], 1'b0} ^ ((sr[NumBits-1] ^ crc[6]) ? 7'h09 : 7'h00))
                              : {crc[5:0], 1'b0};
    end
`else
    assign ser_bit = sr[NumBits-1];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            sr    <= {NumBits{IdleLevel}};
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.abort_i) begin
                state <= IDLE;
                sr    <= {NumBits{IdleLevel}};
                cnt   <= '0;
            end else if (state == IDLE) begin
                if (bus.load_valid_i) begin
                    state <= SHIFT;
                    sr    <= bus.dat_par_i;
                    cnt   <= CW'(Slots);
                end
            end else if (bus.shift_out_en_i) begin
                sr  <= {sr[NumBits-2:0], IdleLevel};
                cnt <= cnt - CW'(cnt != '0);
                if (cnt == CW'(1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign bus.load_ready_o = state == IDLE;
    assign bus.busy_o       = state == SHIFT;
    assign bus.dat_ser_oe_o = state == SHIFT;
    assign bus.dat_ser_o    = state == SHIFT ? ser_bit : IdleLevel;
    assign bus.done_o       = done;
endmodule

// File: tb/tb_par_ser_shift_reg.sv
// tb_par_ser_shift_reg: directed and randomized frames checked every cycle against a bit-queue reference model.
module tb_par_ser_shift_reg;
    localparam int NB = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bit   m_q[$];
    logic m_busy = 1'b0;
    logic m_done = 1'b0;

    always #5 clk = ~clk;

    par_ser_shift_reg_if #(.NumBits(NB)) bus ();

    par_ser_shift_reg #(.NumBits(NB), .IdleLevel(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

`ifdef PAR_SER_CRC7_EN
    // Remainder of word*x^7 divided by x^7+x^3+1 by polynomial long division.
    function automatic logic [6:0] crc7(input logic [NB-1:0] w);
        logic [NB+6:0] r;
        r = {w, 7'b0};
        for (int i = NB + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction
`endif

    task automatic check_outputs();
        chk("ready", 64'(bus.load_ready_o), 64'(!m_busy));
        chk("busy",  64'(bus.busy_o),       64'(m_busy));
        chk("oe",    64'(bus.dat_ser_oe_o), 64'(m_busy));
        chk("ser",   64'(bus.dat_ser_o),    64'(m_busy ? m_q[0] : 1'b1));
        chk("done",  64'(bus.done_o),       64'(m_done));
    endtask

    task automatic model_step(input logic v, input logic [NB-1:0] w, input logic e, input logic a);
        if (rst || a) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_q.delete();
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (v) begin
                m_busy = 1'b1;
                m_q.delete();
                for (int i = NB - 1; i >= 0; i--) m_q.push_back(w[i]);
`ifdef PAR_SER_CRC7_EN
                begin
                    logic [6:0] c;
                    c = crc7(w);
                    for (int i = 6; i >= 0; i--) m_q.push_back(c[i]);
                end
`endif
            end
        end else begin
            m_done = 1'b0;
            if (e) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [NB-1:0] w, input logic e, input logic a);
        @(negedge clk);
        check_outputs();
        bus.load_valid_i   = v;
        bus.dat_par_i      = w;
        bus.shift_out_en_i = e;
        bus.abort_i        = a;
        model_step(v, w, e, a);
    endtask

    function automatic logic [NB-1:0] rnd_word();
        return NB'({$urandom, $urandom});
    endfunction

    initial begin
        logic [NB-1:0] w;
        bus.load_valid_i   = 1'b0;
        bus.dat_par_i      = '0;
        bus.shift_out_en_i = 1'b0;
        bus.abort_i        = 1'b0;
        // Reset holds the block idle even with a load offered.
        cycle(1'b1, rnd_word(), 1'b1, 1'b0);
        cycle(1'b1, rnd_word(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        // Full-rate frame
        cycle(1'b1, NB'(48'hA5C3_0F0F_F00F), 1'b1, 1'b0);
        for (int k = 0; k < NB + 15; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        // One strobe every 4th cycle
        cycle(1'b1, rnd_word(), 1'b0, 1'b0);
        for (int k = 0; k < (NB + 8) * 4 + 10; k++) cycle(1'b0, '0, k % 4 == 3, 1'b0);
        // Abort after 10 strobes, then a complete frame
        cycle(1'b1, rnd_word(), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, rnd_word(), 1'b0, 1'b0);
        for (int k = 0; k < NB + 15; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        // Abort while idle beats a load
        cycle(1'b1, rnd_word(), 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        // Load while busy is ignored; a load held across done starts the next frame
        w = rnd_word();
        cycle(1'b1, rnd_word(), 1'b1, 1'b0);
        for (int k = 0; k < 2 * NB + 30; k++)
            cycle(k == 20 || (k >= NB - 5 && k < NB + 12), k == 20 ? '0 : w, 1'b1, 1'b0);
        // Asynchronous reset mid-frame
        cycle(1'b1, rnd_word(), 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ser",   64'(bus.dat_ser_o),    64'(1));
        chk("arst_oe",    64'(bus.dat_ser_oe_o), 64'(0));
        chk("arst_ready", 64'(bus.load_ready_o), 64'(1));
        chk("arst_busy",  64'(bus.busy_o),       64'(0));
        chk("arst_done",  64'(bus.done_o),       64'(0));
        m_busy = 1'b0;
        m_done = 1'b0;
        m_q.delete();
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        // Randomized traffic
        for (int k = 0; k < 3000; k++)
            cycle($urandom % 6 == 0, rnd_word(), 1'($urandom % 2), $urandom % 80 == 0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
